// File: rtl/popcount32_unary_tx_if.sv
// ---------------------------------------------------------------------------
// popcount32_unary_tx_if
//   Handshake bundle for the count-to-bitstream transmitter.
//
//   Count request side (producer -> transmitter):
//     cnt_valid  request valid
//     cnt_ready  transmitter can accept a count
//     cnt_data   requested number of ones (CW bits)
//     cnt_mode   0 = thermometer, 1 = spread
//
//   Bit stream side (transmitter -> consumer):
//     bit_valid  bit_data/bit_last valid
//     bit_ready  consumer accepts the current bit
//     bit_data   current frame bit
//     bit_last   marks the final bit (index N-1) of a frame
//
//   Status:
//     sat_flag   last accepted count exceeded N and was clamped
//
//   Modports:
//     slave  : the transmitter itself
//     master : the environment (count producer + bit consumer)
// ---------------------------------------------------------------------------
interface popcount32_unary_tx_if #(
  parameter int N  = 32,
  parameter int CW = 6
);

  logic          cnt_valid;
  logic          cnt_ready;
  logic [CW-1:0] cnt_data;
  logic          cnt_mode;

  logic          bit_valid;
  logic          bit_ready;
  logic          bit_data;
  logic          bit_last;

  logic          sat_flag;

  modport slave (
    input  cnt_valid,
    output cnt_ready,
    input  cnt_data,
    input  cnt_mode,
    output bit_valid,
    input  bit_ready,
    output bit_data,
    output bit_last,
    output sat_flag
  );

  modport master (
    output cnt_valid,
    input  cnt_ready,
    output cnt_data,
    output cnt_mode,
    input  bit_valid,
    output bit_ready,
    input  bit_data,
    input  bit_last,
    input  sat_flag
  );

endinterface : popcount32_unary_tx_if

// File: rtl/popcount32_unary_tx.sv
// ---------------------------------------------------------------------------
// popcount32_unary_tx
//   Accepts a population count over a valid/ready handshake and serially
//   emits an N-bit frame containing exactly min(count, N) ones.
//
//   Bit orders:
//     thermometer : ones occupy indices 0..c-1
//     spread      : ones evenly distributed, generated by a modulo-N
//                   accumulator (bit_i = floor((i+1)c/N) - floor(ic/N))
//
//   Ports:
//     clk   sole clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   popcount32_unary_tx_if.slave (count request, bit stream, status)
//
//   All bus outputs are decoded from registered state only; neither
//   bit_ready nor cnt_valid reaches an output combinationally.
// ---------------------------------------------------------------------------
module popcount32_unary_tx #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  popcount32_unary_tx_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // N at the widths it is compared against.
  localparam logic [CW:0]   N_EXT    = (CW + 1)'(N);
  localparam logic [CW-1:0] N_CW     = CW'(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] i_q,     i_d;      // bit index within the frame
  logic [CW-1:0] c_q,     c_d;      // clamped count of ones
  logic [CW:0]   acc_q,   acc_d;    // spread accumulator, always < N
  logic          mode_q,  mode_d;
  logic          sat_q,   sat_d;

  logic          accept;
  logic          beat;
  logic [CW:0]   spread_sum;
  logic          spread_bit;
  logic          therm_bit;
  logic          frame_bit;

  // Handshake qualifiers. cnt_ready/bit_valid are pure state decodes.
  assign accept = (state_q == IDLE) && bus.cnt_valid;
  assign beat   = (state_q == SEND) && bus.bit_ready;

  // acc < N and c <= N, so the sum fits in CW+1 bits without overflow.
  assign spread_sum = acc_q + {1'b0, c_q};
  assign spread_bit = (spread_sum >= N_EXT);
  assign therm_bit  = (i_q < c_q);
  assign frame_bit  = mode_q ? spread_bit : therm_bit;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets a hold-value default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    c_d     = c_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    sat_d   = sat_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Counts above N are clamped; sat_flag remembers that it happened
          // and holds until the next accept.
          if ({1'b0, bus.cnt_data} > N_EXT) begin
            c_d   = N_CW;
            sat_d = 1'b1;
          end else begin
            c_d   = bus.cnt_data;
            sat_d = 1'b0;
          end
          mode_d  = bus.cnt_mode;
          i_d     = '0;
          acc_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        // Without a transfer everything holds, which keeps bit_data and
        // bit_last stable under backpressure.
        if (beat) begin
          if (mode_q) begin
            acc_d = spread_bit ? (spread_sum - N_EXT) : spread_sum;
          end
          if (i_q == LAST_IDX) begin
            i_d     = '0;
            state_d = IDLE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode (registered state only)
  // -------------------------------------------------------------------------
  assign bus.cnt_ready = (state_q == IDLE);
  assign bus.bit_valid = (state_q == SEND);
  assign bus.bit_data  = (state_q == SEND) && frame_bit;
  assign bus.bit_last  = (state_q == SEND) && (i_q == LAST_IDX);
  assign bus.sat_flag  = sat_q;

endmodule : popcount32_unary_tx

// File: tb/tb_popcount32_unary_tx.sv
// ---------------------------------------------------------------------------
// tb_popcount32_unary_tx
//   Directed bench for popcount32_unary_tx. Each accepted count pushes its
//   expected frame (from a closed-form reference) into a scoreboard queue;
//   every transferred beat pops and compares.
// ---------------------------------------------------------------------------
module tb_popcount32_unary_tx;

  localparam int N  = 32;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  popcount32_unary_tx_if #(.N(N), .CW(CW)) bus ();

  popcount32_unary_tx #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_q[$];

  logic [31:0] frame_a;
  logic [31:0] frame_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Closed-form reference, deliberately not the accumulator recurrence.
  function automatic logic [31:0] ref_frame(input int c, input bit mode);
    logic [31:0] f;
    f = '0;
    for (int j = 0; j < N; j++) begin
      if (mode) f[j] = (((j + 1) * c) / N - (j * c) / N) != 0;
      else      f[j] = (j < c);
    end
    return f;
  endfunction

  // Present one count, wait for the accept edge, check first-cycle outputs.
  task automatic send_count(input int cnt, input bit mode);
    int          c;
    int          w;
    logic [31:0] f;
    c = (cnt > N) ? N : cnt;
    f = ref_frame(c, mode);
    for (int j = 0; j < N; j++) exp_q.push_back(f[j]);
    w = 0;
    while (!bus.cnt_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("cnt_ready_before_accept", {31'b0, bus.cnt_ready}, 32'd1);
    bus.cnt_valid = 1'b1;
    bus.cnt_data  = CW'(cnt);
    bus.cnt_mode  = mode;
    @(posedge clk);
    #1;
    bus.cnt_valid = 1'b0;
    bus.cnt_data  = CW'($urandom);
    bus.cnt_mode  = 1'($urandom);
    check("bit_valid_t+1", {31'b0, bus.bit_valid}, 32'd1);
    check("cnt_ready_t+1", {31'b0, bus.cnt_ready}, 32'd0);
    check("sat_flag",      {31'b0, bus.sat_flag},  {31'b0, (cnt > N)});
  endtask

  // Receive nbeats beats, optionally with random backpressure.
  task automatic recv(input bit rnd, input int nbeats, output logic [31:0] frm);
    int   beat;
    int   cyc;
    bit   stalled;
    logic held_d;
    logic held_l;
    logic e;
    beat    = 0;
    cyc     = 0;
    stalled = 1'b0;
    held_d  = 1'b0;
    held_l  = 1'b0;
    frm     = '0;
    while (beat < nbeats && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("stall_valid", {31'b0, bus.bit_valid}, 32'd1);
        check("stall_data",  {31'b0, bus.bit_data},  {31'b0, held_d});
        check("stall_last",  {31'b0, bus.bit_last},  {31'b0, held_l});
      end
      bus.bit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.bit_valid && bus.bit_ready) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $error("FAIL scoreboard_underflow: beat %0d with empty queue", beat);
          e = 1'b0;
        end else begin
          e = exp_q.pop_front();
        end
        check($sformatf("bit_data[%0d]", beat), {31'b0, bus.bit_data}, {31'b0, e});
        check($sformatf("bit_last[%0d]", beat), {31'b0, bus.bit_last}, {31'b0, (beat == N - 1)});
        frm[beat] = bus.bit_data;
        beat++;
        stalled = 1'b0;
      end else if (bus.bit_valid) begin
        stalled = 1'b1;
        held_d  = bus.bit_data;
        held_l  = bus.bit_last;
      end else begin
        stalled = 1'b0;
      end
    end
    check("beats_received", beat, nbeats);
  endtask

  // Cycle after the last beat: back in IDLE, scoreboard drained.
  task automatic post_frame();
    @(negedge clk);
    check("cnt_ready_after_frame", {31'b0, bus.cnt_ready}, 32'd1);
    check("bit_valid_after_frame", {31'b0, bus.bit_valid}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cnt_ready"}, {31'b0, bus.cnt_ready}, 32'd1);
    check({tag, "_bit_valid"}, {31'b0, bus.bit_valid}, 32'd0);
    check({tag, "_bit_data"},  {31'b0, bus.bit_data},  32'd0);
    check({tag, "_bit_last"},  {31'b0, bus.bit_last},  32'd0);
    check({tag, "_sat_flag"},  {31'b0, bus.sat_flag},  32'd0);
  endtask

  initial begin
    bus.cnt_valid = 1'b0;
    bus.cnt_data  = '0;
    bus.cnt_mode  = 1'b0;
    bus.bit_ready = 1'b1;

    // Reset state.
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Count 0, thermometer: all zeros, bit_last only on beat 31, ready at t+33.
    send_count(0, 1'b0);
    recv(1'b0, N, frame_a);
    check("ones_c0", $countones(frame_a), 32'd0);
    post_frame();

    // Count 5, thermometer.
    send_count(5, 1'b0);
    recv(1'b0, N, frame_a);
    check("frame_c5_therm", frame_a, 32'h0000_001F);
    post_frame();

    // Count 8, spread: ones at 3, 7, ..., 31.
    send_count(8, 1'b1);
    recv(1'b0, N, frame_a);
    check("frame_c8_spread", frame_a, 32'h8888_8888);
    post_frame();

    // Count 32, spread: all ones.
    send_count(32, 1'b1);
    recv(1'b0, N, frame_a);
    check("frame_c32_spread", frame_a, 32'hFFFF_FFFF);
    post_frame();

    // Count 40 clamps to 32 with sat_flag; next count 3 clears it.
    send_count(40, 1'b0);
    recv(1'b0, N, frame_a);
    check("frame_c40_therm", frame_a, 32'hFFFF_FFFF);
    check("sat_hold_after_frame", {31'b0, bus.sat_flag}, 32'd1);
    post_frame();
    send_count(3, 1'b1);
    recv(1'b0, N, frame_a);
    check("ones_c3_spread", $countones(frame_a), 32'd3);
    post_frame();

    // Count 17, spread: stall-free then with random backpressure.
    send_count(17, 1'b1);
    recv(1'b0, N, frame_a);
    post_frame();
    send_count(17, 1'b1);
    recv(1'b1, N, frame_b);
    check("ones_c17_stalled", $countones(frame_b), 32'd17);
    check("c17_stalled_vs_free", frame_b, frame_a);
    post_frame();

    // Reset mid-frame at beat 10 of a count-20 frame.
    bus.bit_ready = 1'b1;
    send_count(20, 1'b0);
    recv(1'b0, 10, frame_a);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Fresh frame after reset: count 2, thermometer.
    send_count(2, 1'b0);
    recv(1'b0, N, frame_a);
    check("frame_c2_after_reset", frame_a, 32'h0000_0003);
    post_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_popcount32_unary_tx
